// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run controller: FSM states, halt causes and
// the default length of the CPU clear pulse.
package cpu_dbg_pkg;

    localparam int HOLD_CYCLES_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HALT  = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        HC_NONE  = 2'd0,
        HC_LIMIT = 2'd1,
        HC_BP    = 2'd2,
        HC_STOP  = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/run_trace_buf.sv
// Circular execution trace: one write per executed cycle, the oldest entry is
// overwritten when full, and reads are indexed from the oldest valid entry.
module run_trace_buf #(
    parameter  int DEPTH = 16,
    parameter  int W     = 96,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != (AW+1)'(DEPTH))
                count <= count + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // When full, count[AW-1:0] wraps to zero so the oldest entry is wr_ptr itself.
    assign rd_ptr  = wr_ptr - count[AW-1:0] + rd_idx;
    assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: clear pulse, run/pause/single-step/halt with cycle limit and
// PC breakpoints. Define CPU_RUN_CTRL_TRACE_EN to build the execution trace buffer.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter  int CNT_W       = 32,
    parameter  int NBP         = 2,
    parameter  int TRACE_DEPTH = 16,
    localparam int IW          = $clog2(TRACE_DEPTH)
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic              Step,
    input  logic              Stop,
    input  logic [CNT_W-1:0]  CycleLimit,
    input  logic [NBP-1:0]    BpEn,
    input  logic [NBP*32-1:0] BpAddr,
    input  logic [31:0]       CpuPC,
    input  logic [31:0]       CpuInst,
    input  logic [31:0]       CpuR,
    output logic              CpuClrn,
    output logic              CpuEn,
    output logic [2:0]        State,
    output logic              Halted,
    output logic [1:0]        HaltCause,
    output logic [CNT_W-1:0]  CycleCnt,
    input  logic [IW-1:0]     TrIdx,
    output logic [31:0]       TrPC,
    output logic [31:0]       TrInst,
    output logic [31:0]       TrR,
    output logic [IW:0]       TrCount
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    run_state_e  state, state_nx;
    halt_cause_e cause, cause_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic run_after, run_after_nx;
    logic step_q, step_rise, bp_hit, at_limit, in_reset;

    assign step_rise = Step & ~step_q;
    assign in_reset  = (state == ST_RESET);

    always_comb begin
        bp_hit = 1'b0;
        for (int k = 0; k < NBP; k++)
            if (BpEn[k] && (BpAddr[32*k +: 32] == CpuPC))
                bp_hit = 1'b1;
    end

    // Widened compare so a saturated counter never aliases onto a small limit.
    assign at_limit = (CycleLimit != '0) &&
                      (({1'b0, CycleCnt} + (CNT_W+1)'(1)) == {1'b0, CycleLimit});

    always_comb begin
        state_nx     = state;
        cause_nx     = cause;
        hold_nx      = hold_cnt;
        run_after_nx = run_after;
        CpuEn        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nx     = ST_RESET;
                    hold_nx      = '0;
                    run_after_nx = 1'b1;
                end else if (step_rise) begin
                    state_nx     = ST_RESET;
                    hold_nx      = '0;
                    run_after_nx = 1'b0;
                end
            end
            ST_RESET: begin
                cause_nx = HC_NONE;
                if (hold_cnt == HW'(HOLD_CYCLES - 1))
                    state_nx = run_after ? ST_RUN : ST_PAUSE;
                else
                    hold_nx = hold_cnt + HW'(1);
            end
            ST_RUN: begin
                CpuEn = ~bp_hit;
                if (bp_hit) begin
                    state_nx = ST_HALT;
                    cause_nx = HC_BP;
                end else if (at_limit) begin
                    state_nx = ST_HALT;
                    cause_nx = HC_LIMIT;
                end else if (Stop) begin
                    state_nx = ST_PAUSE;
                    cause_nx = HC_STOP;
                end
            end
            ST_PAUSE: begin
                CpuEn = step_rise & ~Start;
                if (Start)
                    state_nx = ST_RUN;
            end
            ST_HALT: begin
                // Start wins: a simultaneous Step is not accepted.
                CpuEn = step_rise & ~Start;
                if (Start) begin
                    state_nx     = ST_RESET;
                    hold_nx      = '0;
                    run_after_nx = 1'b1;
                end else if (step_rise) begin
                    state_nx = ST_PAUSE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state     <= ST_IDLE;
            cause     <= HC_NONE;
            hold_cnt  <= '0;
            run_after <= 1'b0;
            step_q    <= 1'b0;
            CycleCnt  <= '0;
        end else begin
            state     <= state_nx;
            cause     <= cause_nx;
            hold_cnt  <= hold_nx;
            run_after <= run_after_nx;
            step_q    <= Step;
            if (in_reset)
                CycleCnt <= '0;
            else if (CpuEn && (CycleCnt != '1))
                CycleCnt <= CycleCnt + CNT_W'(1);
        end
    end

    assign State     = state;
    assign HaltCause = cause;
    assign Halted    = (state == ST_HALT);
    assign CpuClrn   = !((state == ST_IDLE) || (state == ST_RESET));

`ifdef CPU_RUN_CTRL_TRACE_EN
    logic [95:0] tr_rd;

    run_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .W     (96)
    ) u_trace (
        .clk     (Clk),
        .rst     (Clr),
        .clear   (in_reset),
        .wr_en   (CpuEn),
        .wr_data ({CpuPC, CpuInst, CpuR}),
        .rd_idx  (TrIdx),
        .rd_data (tr_rd),
        .count   (TrCount)
    );

    assign {TrPC, TrInst, TrR} = tr_rd;
`else
    logic unused_trace;
    assign unused_trace = ^{CpuInst, CpuR, TrIdx};
    assign TrPC    = '0;
    assign TrInst  = '0;
    assign TrR     = '0;
    assign TrCount = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random control traffic, all
// checked every cycle against a rule-level model of the controller.
module tb_cpu_run_ctrl;

    localparam int CW   = 8;
    localparam int NBP  = 2;
    localparam int TD   = 16;
    localparam int IW   = 4;
    localparam int HOLD = 5;

    logic Clk = 1'b0;
    logic Clr = 1'b1, Start = 1'b0, Step = 1'b0, Stop = 1'b0;
    logic [CW-1:0]     CycleLimit = '0;
    logic [NBP-1:0]    BpEn = '0;
    logic [NBP*32-1:0] BpAddr = '0;
    logic [31:0]       CpuPC = '0, CpuInst = '0, CpuR = '0;
    logic              CpuClrn, CpuEn, Halted;
    logic [2:0]        State;
    logic [1:0]        HaltCause;
    logic [CW-1:0]     CycleCnt;
    logic [IW-1:0]     TrIdx = '0;
    logic [31:0]       TrPC, TrInst, TrR;
    logic [IW:0]       TrCount;

    int n_cmp = 0;
    int n_bad = 0;
    int en_seen = 0;

    always #5 Clk = ~Clk;

    cpu_run_ctrl #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW),
        .NBP         (NBP),
        .TRACE_DEPTH (TD)
    ) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .Start      (Start),
        .Step       (Step),
        .Stop       (Stop),
        .CycleLimit (CycleLimit),
        .BpEn       (BpEn),
        .BpAddr     (BpAddr),
        .CpuPC      (CpuPC),
        .CpuInst    (CpuInst),
        .CpuR       (CpuR),
        .CpuClrn    (CpuClrn),
        .CpuEn      (CpuEn),
        .State      (State),
        .Halted     (Halted),
        .HaltCause  (HaltCause),
        .CycleCnt   (CycleCnt),
        .TrIdx      (TrIdx),
        .TrPC       (TrPC),
        .TrInst     (TrInst),
        .TrR        (TrR),
        .TrCount    (TrCount)
    );

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Rule-level model: mode number, remaining clear cycles, counter, trace queue.
    int          m_st = 0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    bit          m_to_run = 1'b0;
    int          m_cnt = 0;
    int          m_cause = 0;
    bit          m_stepq = 1'b0;
    logic [95:0] m_tr[$];

    always @(negedge Clk) begin : model
        bit          rise, bp, en;
        int          old;
        logic [95:0] exp_tr;
        rise = Step && !m_stepq;
        bp = 1'b0;
        for (int k = 0; k < NBP; k++)
            if (BpEn[k] && BpAddr[32*k +: 32] == CpuPC) bp = 1'b1;
        en = (m_st == 2 && !bp) || ((m_st == 3 || m_st == 4) && rise && !Start);
        if (m_valid) begin
            check("state", State, m_st);
            check("cpu_clrn", CpuClrn, (m_st >= 2));
            check("cpu_en", CpuEn, en);
            check("halted", Halted, (m_st == 4));
            check("halt_cause", HaltCause, m_cause);
            check("cycle_cnt", CycleCnt, m_cnt);
`ifdef CPU_RUN_CTRL_TRACE_EN
            exp_tr = (int'(TrIdx) < m_tr.size()) ? m_tr[int'(TrIdx)] : '0;
            check("tr_count", TrCount, m_tr.size());
`else
            exp_tr = '0;
            check("tr_count", TrCount, 0);
`endif
            check("tr_pc", TrPC, exp_tr[95:64]);
            check("tr_inst", TrInst, exp_tr[63:32]);
            check("tr_r", TrR, exp_tr[31:0]);
        end
        if (Clr) begin
            m_valid = 1'b1;
            m_st = 0; m_cnt = 0; m_cause = 0; m_stepq = 1'b0;
            m_tr.delete();
        end else if (m_valid) begin
            old = m_cnt;
            if (en) begin
                if (m_cnt < (2**CW) - 1) m_cnt++;
                m_tr.push_back({CpuPC, CpuInst, CpuR});
                if (m_tr.size() > TD) void'(m_tr.pop_front());
            end
            case (m_st)
                0: if (Start || rise) begin
                       m_st = 1; m_left = HOLD; m_to_run = Start;
                   end
                1: begin
                       m_cnt = 0; m_cause = 0; m_tr.delete();
                       m_left--;
                       if (m_left == 0) m_st = m_to_run ? 2 : 3;
                   end
                2: if (bp) begin
                       m_st = 4; m_cause = 2;
                   end else if (CycleLimit != 0 && old + 1 == int'(CycleLimit)) begin
                       m_st = 4; m_cause = 1;
                   end else if (Stop) begin
                       m_st = 3; m_cause = 3;
                   end
                3: if (Start) m_st = 2;
                4: if (Start) begin
                       m_st = 1; m_left = HOLD; m_to_run = 1'b1;
                   end else if (rise) m_st = 3;
                default: m_st = 0;
            endcase
            m_stepq = Step;
        end
    end

    // One clock; a simple fake CPU advances its PC by 4 on each enabled cycle.
    task automatic tick();
        bit e, c;
        @(negedge Clk);
        e = CpuEn;
        c = CpuClrn;
        if (e) en_seen++;
        @(posedge Clk);
        #1;
        if (!c) CpuPC = '0;
        else if (e) CpuPC = CpuPC + 32'd4;
        CpuInst = $urandom;
        CpuR = $urandom;
    endtask

    task automatic clr_pulse();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_halt(int maxc, string name);
        int n;
        n = 0;
        while (!Halted && n < maxc) begin
            tick();
            n++;
        end
        check({name, "_halt_reached"}, Halted, 1);
    endtask

    initial begin : stim
        int n;
        tick();
        clr_pulse();
        check("rst_state", State, 0);
        check("rst_clrn", CpuClrn, 0);
        check("rst_en", CpuEn, 0);
        check("rst_cnt", CycleCnt, 0);
        check("rst_cause", HaltCause, 0);
        check("rst_trcount", TrCount, 0);

        // Start from idle: clear pulse length, then running
        start_pulse();
        n = 0;
        while (State == 3'd1 && n < 20) begin
            if (!CpuClrn) n++;
            tick();
        end
        check("hold_cycles", n, HOLD);
        check("run_state", State, 2);
        check("run_en", CpuEn, 1);

        // Stop, then a held Step executes once
        Stop = 1'b1; tick(); Stop = 1'b0;
        check("stop_state", State, 3);
        check("stop_cause", HaltCause, 3);
        en_seen = 0;
        Step = 1'b1;
        repeat (8) tick();
        Step = 1'b0;
        tick();
        check("held_step_pulses", en_seen, 1);
        check("held_step_state", State, 3);

        // Cycle limit
        clr_pulse();
        CycleLimit = 8'd10;
        start_pulse();
        en_seen = 0;
        wait_halt(100, "limit");
        check("limit_pulses", en_seen, 10);
        check("limit_cause", HaltCause, 1);
        check("limit_cnt", CycleCnt, 10);

        // Breakpoint at 0x0C, second breakpoint disabled
        clr_pulse();
        CycleLimit = '0;
        BpEn = 2'b01;
        BpAddr = {32'h0000_0010, 32'h0000_000C};
        start_pulse();
        en_seen = 0;
        wait_halt(100, "bp");
        check("bp_pc", CpuPC, 32'h0C);
        check("bp_en", CpuEn, 0);
        check("bp_cause", HaltCause, 2);
        check("bp_pulses", en_seen, 3);
        en_seen = 0;
        Step = 1'b1; tick(); Step = 1'b0; tick();
        check("bp_step_pulses", en_seen, 1);
        check("bp_step_state", State, 3);

        // Trace after 20 executed cycles
        clr_pulse();
        BpEn = '0;
        CycleLimit = 8'd20;
        start_pulse();
        wait_halt(100, "trace");
        check("trace_cnt", CycleCnt, 20);
`ifdef CPU_RUN_CTRL_TRACE_EN
        TrIdx = 4'd0; #1;
        check("trace_count_full", TrCount, 16);
        check("trace_oldest_pc", TrPC, 32'h10);
        TrIdx = 4'd15; #1;
        check("trace_newest_pc", TrPC, 32'h4C);
`else
        TrIdx = 4'd0; #1;
        check("trace_off_count", TrCount, 0);
        check("trace_off_pc", TrPC, 0);
`endif

        // Counter saturation
        clr_pulse();
        CycleLimit = '0;
        start_pulse();
        repeat (HOLD + 300) tick();
        check("sat_cnt", CycleCnt, 255);
        check("sat_state", State, 2);

        // Clear on the 3rd cycle of the CPU clear pulse
        clr_pulse();
        start_pulse();
        tick();
        tick();
        check("mid_reset_state", State, 1);
        clr_pulse();
        check("midrst_state", State, 0);
        check("midrst_clrn", CpuClrn, 0);
        check("midrst_en", CpuEn, 0);
        check("midrst_cnt", CycleCnt, 0);
        check("midrst_halted", Halted, 0);
        check("midrst_cause", HaltCause, 0);
        check("midrst_trcount", TrCount, 0);

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            Start = ($urandom_range(0, 29) == 0);
            Stop  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) Step = ~Step;
            Clr   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) begin
                CycleLimit = CW'($urandom_range(0, 40));
                BpEn = NBP'($urandom);
                BpAddr = {32'($urandom_range(0, 24) * 4), 32'($urandom_range(0, 24) * 4)};
            end
            TrIdx = IW'($urandom);
            tick();
        end
        Clr = 1'b0; Start = 1'b0; Stop = 1'b0; Step = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: Clk, Clr (sampled only on posedge Clk).
REQ-002 Parameters SHALL be (name, default, meaning):
- HOLD_CYCLES, 5, cycles CpuClrn is held low per run.
- CNT_W, 32, cycle counter/limit width.
- NBP, 2, number of PC breakpoints.
- TRACE_DEPTH, 16, trace entries (power of 2, >=2).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- Clk in 1 clock; Clr in 1 sync active-high reset.
- Start in 1 run request; Step in 1 single-step request; Stop in 1 pause request.
- CycleLimit in CNT_W halt after this many executed cycles, 0 = unlimited.
- BpEn in NBP per-breakpoint enable; BpAddr in NBP*32 breakpoint PCs, entry k at [32k+31:32k].
- CpuPC, CpuInst, CpuR in 32 each, CPU observation.
- CpuClrn out 1 active-low CPU clear; CpuEn out 1 CPU clock enable.
- State out 3 FSM state; Halted out 1; HaltCause out 2 (0 none, 1 limit, 2 breakpoint, 3 stop).
- CycleCnt out CNT_W executed-cycle count.
- TrIdx in log2(TRACE_DEPTH) read index; TrPC, TrInst, TrR out 32 each; TrCount out log2(TRACE_DEPTH)+1.

Function
REQ-004 FSM states SHALL be IDLE=0, RESET=1, RUN=2, PAUSE=3, HALT=4.
REQ-005 IDLE: Start->RESET (then RUN); else Step->RESET (then PAUSE); Start wins over Step.
REQ-006 RESET SHALL hold CpuClrn=0 and CpuEn=0 for exactly HOLD_CYCLES cycles, clear CycleCnt, HaltCause and trace, then exit.
REQ-007 CpuClrn SHALL be 1 in every state except RESET and IDLE.
REQ-008 CpuEn SHALL be combinational: 1 in RUN when no enabled breakpoint equals CpuPC; 1 for exactly one cycle per accepted Step in PAUSE or HALT; else 0.
REQ-009 RUN exit priority: breakpoint hit -> HALT cause 2, instruction at CpuPC not executed; else CycleCnt+1 == CycleLimit (limit nonzero) on an executed cycle -> HALT cause 1; else Stop -> PAUSE cause 3.
REQ-010 PAUSE: Start->RUN; Step executes one instruction, breakpoints ignored, stays PAUSE.
REQ-011 HALT: Start->RESET (full rerun); Step executes one instruction ignoring breakpoints then ->PAUSE; Halted=1 only in HALT.
REQ-012 CycleCnt SHALL increment on each cycle with CpuEn=1 and saturate at all-ones.
REQ-013 Each CpuEn=1 cycle SHALL write {CpuPC,CpuInst,CpuR} into a circular trace; when full, the oldest entry is overwritten; TrCount saturates at TRACE_DEPTH.
REQ-014 Trace read SHALL be combinational; TrIdx=0 is oldest valid entry; TrIdx>=TrCount returns zeros.
REQ-015 Start/Step/Stop SHALL be level-sampled; Step is rising-edge detected internally so a held Step executes once.

Reset
REQ-016 Clr=1 SHALL, at the next posedge, force IDLE, CpuClrn=0, CpuEn=0, CycleCnt=0, Halted=0, HaltCause=0, TrCount=0, regardless of state, including mid-RESET or mid-step.

Configuration
REQ-017 CPU_RUN_CTRL_TRACE_EN defined: trace buffer per REQ-013/014 built. Undefined: no storage, TrPC/TrInst/TrR/TrCount tied 0; all other behaviour unchanged.

Structure
REQ-018 Package cpu_dbg_pkg SHALL hold state encodings, HaltCause codes and the default HOLD_CYCLES.
REQ-019 The trace SHALL be sub-module run_trace_buf (write port, index read port, count), instantiated only under CPU_RUN_CTRL_TRACE_EN.

Verification
REQ-020 Clr 1 cycle, Start 1 cycle -> CpuClrn low exactly 5 cycles, then State=2, CpuEn=1.
REQ-021 CycleLimit=10, Start -> exactly 10 CpuEn cycles, Halted=1, HaltCause=1, CycleCnt=10.
REQ-022 BpEn=01, BpAddr[31:0]=0x0000000C, PC stepping by 4 -> halt with CpuPC=0x0C, CpuEn=0 that cycle, HaltCause=2; then Step -> one CpuEn pulse, State=3.
REQ-023 Step held high 8 cycles from PAUSE -> exactly one CpuEn pulse; Stop during RUN -> State=3, HaltCause=3.
REQ-024 With trace enabled, 20 executed cycles -> TrCount=16, TrIdx=0 returns 5th executed PC.
REQ-025 Clr asserted on 3rd RESET cycle -> next cycle State=0, all outputs at reset values.
